data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_pkg.sv | 22 ++
 rtl/data_mem_resp_if.sv | 30 +++
 rtl/data_mem_resp_sb_fifo.sv | 74 +++++++
 rtl/data_mem_resp.sv | 146 ++++++++++++++
 tb/tb_data_mem_resp.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_resp_pkg
// Shared constants and the store-buffer entry type used by the data-memory
// response block, its core-side interface and its store-buffer FIFO.
//   ADDR_W     : word-address width presented to the data SRAM
//   LANES      : byte lanes per word
//   DATA_W     : word width
//   sb_entry_t : one buffered store {addr, mask, data}
// -----------------------------------------------------------------------------
package data_mem_resp_pkg;

  localparam int ADDR_W = 8;
  localparam int LANES  = 4;
  localparam int DATA_W = 8 * LANES;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/data_mem_resp_if.sv
// -----------------------------------------------------------------------------
// data_mem_resp_if
// Core-side load/store bus of the data-memory response block.
//   load_req   : per-lane load request, nonzero = load this cycle
//   store_req  : per-lane store request, nonzero = store this cycle
//   addr       : word address (low ADDR_W bits used)
//   store_data : lane-aligned store data
//   load_data  : load result, valid the cycle after load_req
// master = core side, slave = data_mem_resp.
// -----------------------------------------------------------------------------
interface data_mem_resp_if;
  import data_mem_resp_pkg::*;

  logic [LANES-1:0]  load_req;
  logic [LANES-1:0]  store_req;
  logic [31:0]       addr;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] load_data;

  modport master (
    output load_req, store_req, addr, store_data,
    input  load_data
  );

  modport slave (
    input  load_req, store_req, addr, store_data,
    output load_data
  );

endinterface

// File: rtl/data_mem_resp_sb_fifo.sv
// -----------------------------------------------------------------------------
// sb_fifo
// Two-entry store-buffer FIFO. Both entries are visible so the parent can do
// a forwarding lookup against every buffered store.
//   clk, rst : clock, synchronous active-high reset (clears occupancy only)
//   i_push   : enqueue i_entry (accepted when not full or when popping)
//   i_entry  : entry to enqueue
//   i_pop    : dequeue the oldest entry (ignored when empty)
//   o_head   : oldest entry
//   o_tail   : second (younger) entry
//   o_valid  : per-entry valid, [0]=head, [1]=tail
//   o_empty  : no entries held
// -----------------------------------------------------------------------------
module sb_fifo
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  sb_entry_t i_entry,
  input  logic      i_pop,
  output sb_entry_t o_head,
  output sb_entry_t o_tail,
  output logic [1:0] o_valid,
  output logic      o_empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] r_count;
  sb_entry_t        r_ent0;
  sb_entry_t        r_ent1;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop && (r_count != '0);
  // A push into a full buffer is legal only when the head leaves the same cycle.
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  // Entry storage is validated by r_count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_pop_ok) begin
      r_ent0 <= (w_push_ok && r_count == CNT_W'(1)) ? i_entry : r_ent1;
      if (w_push_ok && w_full) begin
        r_ent1 <= i_entry;
      end
    end else if (w_push_ok) begin
      if (r_count == '0) begin
        r_ent0 <= i_entry;
      end else begin
        r_ent1 <= i_entry;
      end
    end
  end

  assign o_head     = r_ent0;
  assign o_tail     = r_ent1;
  assign o_valid[0] = (r_count != '0);
  assign o_valid[1] = w_full;
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/data_mem_resp.sv
// -----------------------------------------------------------------------------
// data_mem_resp
// Data-memory front end between the core and an external single-port SRAM.
// Stores are absorbed by a 2-entry store buffer and drained in cycles without
// a load; loads go straight to the SRAM and have buffered bytes forwarded.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : core load/store bus (slave modport)
//   sram_cen   : SRAM chip enable, active-low
//   sram_wen   : SRAM per-lane write enable, active-low
//   sram_a     : SRAM word address
//   sram_d     : SRAM write data
//   sram_q     : SRAM read data, one-cycle latency
//   sb_empty   : store buffer empty (SRAM coherent)
//   err        : sticky flag, load and store requested in the same cycle
// -----------------------------------------------------------------------------
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int ADDR_W   = data_mem_resp_pkg::ADDR_W,
  parameter int SB_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_resp_if.slave     bus,
  output logic               sram_cen,
  output logic [LANES-1:0]   sram_wen,
  output logic [ADDR_W-1:0]  sram_a,
  output logic [DATA_W-1:0]  sram_d,
  input  logic [DATA_W-1:0]  sram_q,
  output logic               sb_empty,
  output logic               err
);

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] q,
                                                    input logic [DATA_W-1:0] fd,
                                                    input logic [LANES-1:0]  fm);
    logic [DATA_W-1:0] r;
    for (int l = 0; l < LANES; l++) begin
      r[8*l +: 8] = fm[l] ? fd[8*l +: 8] : q[8*l +: 8];
    end
    return r;
  endfunction

  logic              w_ld;
  logic              w_st;
  logic              w_push;
  logic              w_drain;
  logic              w_empty;
  logic [1:0]        w_valid;
  logic [ADDR_W-1:0] w_ld_addr;
  logic              w_unused_addr;
  sb_entry_t         w_new;
  sb_entry_t         w_head;
  sb_entry_t         w_tail;
  logic [LANES-1:0]  w_fwd_mask;
  logic [DATA_W-1:0] w_fwd_data;
  logic [DATA_W-1:0] w_merged;

  logic              r_ld_vld_p1;
  logic [LANES-1:0]  r_fwd_mask_p1;
  logic [DATA_W-1:0] r_fwd_data_p1;
  logic [DATA_W-1:0] r_load_data;
  logic              r_err;

  // ---- Stage p0: request decode, store-buffer push/drain, SRAM command ----
  assign w_ld          = (bus.load_req != '0) && !rst;
  assign w_st          = (bus.store_req != '0) && !rst;
  // A store alongside a load is dropped; the load always wins.
  assign w_push        = w_st && !w_ld;
  assign w_drain       = !w_ld && !w_empty && !rst;
  assign w_ld_addr     = bus.addr[ADDR_W-1:0];
  assign w_unused_addr = ^bus.addr[31:ADDR_W];
  assign w_new         = '{addr: w_ld_addr, mask: bus.store_req, data: bus.store_data};

  sb_fifo #(.DEPTH(SB_DEPTH)) u_sb_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_new),
    .i_pop   (w_drain),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_valid (w_valid),
    .o_empty (w_empty)
  );

  always_comb begin
    sram_cen = 1'b1;
    sram_wen = '1;
    sram_a   = '0;
    sram_d   = '0;
    if (w_ld) begin
      sram_cen = 1'b0;
      sram_a   = w_ld_addr;
    end else if (w_drain) begin
      sram_cen = 1'b0;
      sram_wen = ~w_head.mask;
      sram_a   = w_head.addr;
      sram_d   = w_head.data;
    end
  end

  // The tail is younger than the head, so it is checked first per lane.
  always_comb begin
    w_fwd_mask = '0;
    w_fwd_data = '0;
    for (int l = 0; l < LANES; l++) begin
      if (w_valid[1] && w_tail.addr == w_ld_addr && w_tail.mask[l]) begin
        w_fwd_mask[l]       = 1'b1;
        w_fwd_data[8*l +: 8] = w_tail.data[8*l +: 8];
      end else if (w_valid[0] && w_head.addr == w_ld_addr && w_head.mask[l]) begin
        w_fwd_mask[l]       = 1'b1;
        w_fwd_data[8*l +: 8] = w_head.data[8*l +: 8];
      end
    end
  end

  // ---- Stage p1: SRAM data returns, forwarded lanes override ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_vld_p1   <= 1'b0;
      r_fwd_mask_p1 <= '0;
      r_fwd_data_p1 <= '0;
      r_load_data   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_ld_vld_p1 <= w_ld;
      if (w_ld) begin
        r_fwd_mask_p1 <= w_fwd_mask;
        r_fwd_data_p1 <= w_fwd_data;
      end
      if (r_ld_vld_p1) begin
        r_load_data <= w_merged;
      end
      if (w_st && w_ld) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_merged      = merge_lanes(sram_q, r_fwd_data_p1, r_fwd_mask_p1);
  assign bus.load_data = r_ld_vld_p1 ? w_merged : r_load_data;
  assign sb_empty      = w_empty || rst;
  assign err           = r_err;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_cen;
  logic [3:0]  sram_wen;
  logic [7:0]  sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;
  logic        sb_empty;
  logic        err;

  always #5 clk = ~clk;

  data_mem_resp_if bus();

  data_mem_resp #(.ADDR_W(8), .SB_DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .sram_cen (sram_cen),
    .sram_wen (sram_wen),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_q   (sram_q),
    .sb_empty (sb_empty),
    .err      (err)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    if (i == 'h30) return 32'hAABBCCDD;
    if (i == 'h40) return 32'h55667788;
    return {4{b}} ^ 32'h5A5A5A5A;
  endfunction

  // Behavioural SRAM: byte-lane write, one-cycle read latency.
  logic [31:0] mem [256];
  logic        mem_init = 1'b1;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (!sram_cen) begin
      for (int l = 0; l < 4; l++)
        if (!sram_wen[l]) mem[sram_a][8*l +: 8] <= sram_d[8*l +: 8];
      if (sram_wen != 4'hF) wr_cnt <= wr_cnt + 1;
      sram_q <= mem[sram_a];
    end
  end

  // Core-view reference image and load scoreboard.
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];
  logic [31:0] last_ld;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_load();
    logic [31:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("load_data", bus.load_data, e);
      last_ld = e;
    end else begin
      chk("load_hold", bus.load_data, last_ld);
    end
  endtask

  task automatic cycle(input logic [3:0] ld, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    logic [7:0] ai;
    @(negedge clk);
    check_load();
    bus.load_req   = ld;
    bus.store_req  = st;
    bus.addr       = a;
    bus.store_data = d;
    ai = a[7:0];
    if (ld != 4'h0) begin
      exp_q.push_back(ref_mem[ai]);
    end else if (st != 4'h0) begin
      for (int l = 0; l < 4; l++)
        if (st[l]) ref_mem[ai][8*l +: 8] = d[8*l +: 8];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.load_req  = 4'h0;
    bus.store_req = 4'h0;
    exp_q.delete();
    #1;
    chk("rst_cen", 32'(sram_cen), 32'h1);
    chk("rst_wen", 32'(sram_wen), 32'hF);
    chk("rst_sb_empty", 32'(sb_empty), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_load_data", bus.load_data, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_sb_empty_after", 32'(sb_empty), 32'h1);
    last_ld = 32'h0;
  endtask

  typedef struct {
    logic [3:0]  ld;
    logic [3:0]  st;
    logic [31:0] a;
    logic [31:0] d;
    logic        e_cen;
    logic [3:0]  e_wen;
    logic [7:0]  e_a;
    logic        e_empty;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int          w0;
    int          bad;
    logic [31:0] saved70;

    tbl[0]  = '{4'h0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 8'h00, 1'b1};
    tbl[1]  = '{4'h0, 4'h0, 32'h00, 32'h0,        1'b0, 4'h0, 8'h10, 1'b0};
    tbl[2]  = '{4'h0, 4'h0, 32'h00, 32'h0,        1'b1, 4'hF, 8'h00, 1'b1};
    tbl[3]  = '{4'h0, 4'h0, 32'h00, 32'h0,        1'b1, 4'hF, 8'h00, 1'b1};
    tbl[4]  = '{4'h0, 4'hF, 32'h20, 32'h11223344, 1'b1, 4'hF, 8'h00, 1'b1};
    tbl[5]  = '{4'hF, 4'h0, 32'h20, 32'h0,        1'b0, 4'hF, 8'h20, 1'b0};
    tbl[6]  = '{4'h0, 4'h0, 32'h00, 32'h0,        1'b0, 4'h0, 8'h20, 1'b0};
    tbl[7]  = '{4'h0, 4'h1, 32'h30, 32'h000000EE, 1'b1, 4'hF, 8'h00, 1'b1};
    tbl[8]  = '{4'hF, 4'h0, 32'h30, 32'h0,        1'b0, 4'hF, 8'h30, 1'b0};
    tbl[9]  = '{4'h0, 4'h3, 32'h40, 32'h00001111, 1'b0, 4'hE, 8'h30, 1'b0};
    tbl[10] = '{4'h0, 4'h1, 32'h40, 32'h00000022, 1'b0, 4'hC, 8'h40, 1'b0};
    tbl[11] = '{4'hF, 4'h0, 32'h40, 32'h0,        1'b0, 4'hF, 8'h40, 1'b0};
    tbl[12] = '{4'h0, 4'h0, 32'h00, 32'h0,        1'b0, 4'hE, 8'h40, 1'b0};
    tbl[13] = '{4'h0, 4'h0, 32'h00, 32'h0,        1'b1, 4'hF, 8'h00, 1'b1};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    bus.load_req   = 4'h0;
    bus.store_req  = 4'h0;
    bus.addr       = 32'h0;
    bus.store_data = 32'h0;
    last_ld        = 32'h0;

    // Initial reset; SRAM model preloaded meanwhile.
    @(negedge clk);
    #1;
    chk("init_cen", 32'(sram_cen), 32'h1);
    chk("init_wen", 32'(sram_wen), 32'hF);
    chk("init_sb_empty", 32'(sb_empty), 32'h1);
    chk("init_load_data", bus.load_data, 32'h0);
    chk("init_err", 32'(err), 32'h0);
    @(negedge clk);
    mem_init = 1'b0;
    rst      = 1'b0;

    // Directed vector table.
    w0 = wr_cnt;
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].ld, tbl[i].st, tbl[i].a, tbl[i].d);
      #1;
      chk($sformatf("v%0d_cen", i), 32'(sram_cen), 32'(tbl[i].e_cen));
      chk($sformatf("v%0d_wen", i), 32'(sram_wen), 32'(tbl[i].e_wen));
      if (!tbl[i].e_cen) chk($sformatf("v%0d_addr", i), 32'(sram_a), 32'(tbl[i].e_a));
      chk($sformatf("v%0d_sb_empty", i), 32'(sb_empty), 32'(tbl[i].e_empty));
    end
    cycle(4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("write_count", 32'(wr_cnt - w0), 32'd5);
    chk("mem_10", mem['h10], 32'hDEADBEEF);
    chk("mem_30", mem['h30], 32'hAABBCCEE);
    chk("mem_40", mem['h40], 32'h55661122);

    // Alternating store/load traffic on a small address window.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0)
        cycle(4'h0, 4'($urandom_range(1, 15)), 32'h50 + 32'($urandom_range(0, 3)), $urandom);
      else
        cycle(4'hF, 4'h0, 32'h50 + 32'($urandom_range(0, 3)), 32'h0);
    end
    repeat (3) cycle(4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("sram_image", 32'(bad), 32'h0);
    chk("traffic_sb_empty", 32'(sb_empty), 32'h1);

    // Load and store together: load wins, store dropped, err sticks.
    cycle(4'hF, 4'hF, 32'h60, 32'hCAFEF00D);
    cycle(4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("conflict_err", 32'(err), 32'h1);
    chk("conflict_sb_empty", 32'(sb_empty), 32'h1);
    repeat (3) cycle(4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("conflict_err_sticky", 32'(err), 32'h1);
    chk("conflict_mem_60", mem['h60], init_word('h60));

    // Reset with a pending store and a load in flight.
    saved70 = ref_mem['h70];
    cycle(4'h0, 4'hF, 32'h70, 32'h12345678);
    cycle(4'hF, 4'h0, 32'h71, 32'h0);
    do_reset();
    ref_mem['h70] = saved70;
    repeat (3) cycle(4'h0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("reset_drop_mem_70", mem['h70], init_word('h70));
    chk("reset_sb_empty", 32'(sb_empty), 32'h1);

    // Forwarding still works after reset.
    cycle(4'h0, 4'h6, 32'h70, 32'h00ABCD00);
    cycle(4'hF, 4'h0, 32'h70, 32'h0);
    repeat (3) cycle(4'h0, 4'h0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
